hazard_fwd_ctrl: RTL
====================

Name: hazard_fwd_ctrl

Overview:
- Parametrised pipeline hazard/forwarding controller for the pipelined MIPS core; replaces the separate fixed forwarding unit and load-use detector.
- Keeps a scoreboard shift register of NSTAGE post-ID stages (stage 0 = EX … stage NSTAGE-1 = WB), holding each stage's destination register.
- Outputs operand-forwarding selects for the instruction in EX, and load-use stall, bubble and flush controls for PC, IF/ID and ID/EX.

Parameters:
- REG_AW, 5, register address width.
- NSTAGE, 3, number of tracked stages after ID (EX, MEM, WB); legal range 2..8.
- LOAD_RDY, 2, lowest stage index from which load data may be forwarded; 1 ≤ LOAD_RDY ≤ NSTAGE-1.
- CNT_W, 32, stall-counter width.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- id_valid_i, in, 1, ID holds a real instruction.
- id_rs_i, in, REG_AW, RS address of the ID instruction.
- id_rt_i, in, REG_AW, RT address of the ID instruction.
- id_use_rs_i, in, 1, ID instruction reads RS.
- id_use_rt_i, in, 1, ID instruction reads RT.
- id_rd_i, in, REG_AW, destination register after RegDst mux.
- id_regwrite_i, in, 1, ID instruction writes a register.
- id_memread_i, in, 1, ID instruction is a load.
- flush_i, in, 1, taken branch/jump resolved in EX.
- ex_stall_i, in, 1, external back-pressure (data memory busy); freezes the pipe.
- pcwrite_o, out, 1, PC write enable.
- ifid_write_o, out, 1, IF/ID write enable.
- ifid_flush_o, out, 1, clear IF/ID.
- idex_bubble_o, out, 1, insert NOP into ID/EX.
- fwd_rs_o, out, $clog2(NSTAGE), RS source for EX: 0 = ID/EX register value, k = result of stage k.
- fwd_rt_o, out, $clog2(NSTAGE), same encoding for RT.
- stall_cnt_o, out, CNT_W, count of load-use stall cycles.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous and active-high.
- Reset: all stage entries invalid; stall_cnt_o=0. Resulting outputs: pcwrite_o=1, ifid_write_o=1, ifid_flush_o=0, idex_bubble_o=0, fwd_*=0.
- Scoreboard entry fields: valid, rd, regwrite, memread.
- Entry with rd=0 or regwrite=0 never matches anything.
- Each EX source also records use_rs/use_rt; these are captured at issue.
- Forwarding (combinational from state):
  - For each EX source with use=1, choose the smallest k in 1..NSTAGE-1 whose entry matches the source address. Youngest wins.
  - Memread entries match only when k ≥ LOAD_RDY.
  - No match gives 0.
- Load-use hazard (combinational):
  - Condition: id_valid_i, and a used ID source matches a memread entry in stage s with s+1 < LOAD_RDY.
  - Default parameters: only stage 0 (EX) triggers, giving one stall cycle.
  - With LOAD_RDY=3, a load in stage 0 then stage 1 gives 2 stall cycles.
- Priority per cycle: rst_i > ex_stall_i > flush_i > load-use.
- ex_stall_i=1:
  - All entries hold.
  - pcwrite_o=0, ifid_write_o=0, idex_bubble_o=0.
  - flush_i is ignored; the source must hold flush_i until a non-stall cycle.
  - stall_cnt_o does not count.
- Advance cycle (ex_stall_i=0):
  - Entries shift: stage k ← stage k-1; stage NSTAGE-1 retires.
  - Stage 0 input depends on the case below.
- flush_i=1:
  - Stage 0 ← bubble; ifid_flush_o=1; pcwrite_o=1.
  - The ID instruction is discarded.
  - A simultaneous load-use condition is suppressed and not counted.
- Load-use stall (no flush):
  - Stage 0 ← bubble; idex_bubble_o=1; pcwrite_o=0; ifid_write_o=0.
  - stall_cnt_o increments by 1, wrapping at 2^CNT_W.
- Normal advance:
  - Stage 0 ← ID fields, valid = id_valid_i.
  - pcwrite_o=1, ifid_write_o=1.
- Mid-operation reset: all in-flight entries are dropped in the same cycle; there is no forwarding on the next cycle.

Decomposition:
- Shared package cpu_pkg:
  - REG_AW default.
  - sb_entry_t struct (valid, rd, regwrite, memread).
  - FWD_REGFILE=0 constant.
- One sub-module, hazard_match: compares one source address against a single entry with LOAD_RDY qualification. Instantiated 2×NSTAGE times.

Test Plan:
1. ALU chain:
   - Stimulus: add $3,$1,$2 then sub $4,$3,$5 issued back-to-back.
   - Required: when sub is in EX, fwd_rs_o=1 and fwd_rt_o=0; no stall.
2. Double match:
   - Stimulus: writes to $3 sit in stage 1 and stage 2.
   - Required: fwd_rs_o=1 (youngest wins). With rd=$0 in both stages, fwd_rs_o=0.
3. Load-use:
   - Stimulus: lw $3 followed by add $4,$3,$1.
   - Required: exactly one cycle with pcwrite_o=0, ifid_write_o=0, idex_bubble_o=1; stall_cnt_o 0→1; then fwd_rs_o=2.
4. Flush vs hazard:
   - Stimulus: flush_i=1 in the same cycle as a load-use condition.
   - Required: ifid_flush_o=1, pcwrite_o=1, idex_bubble_o=0, stall_cnt_o unchanged.
5. ex_stall_i:
   - Stimulus: hold ex_stall_i=1 for 3 cycles with a forward active.
   - Required: fwd_* constant, pcwrite_o=0, entries frozen; normal shift resumes on release.
6. Reset and parameters:
   - Stimulus: assert rst_i with the pipe full.
   - Required: next cycle fwd_*=0, stall_cnt_o=0, pcwrite_o=1.
   - Stimulus: NSTAGE=4, LOAD_RDY=3, load-use pair.
   - Required: 2 stall cycles, then fwd_rs_o=3.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cpu_pkg
// Summary  : Shared types and constants for the pipelined MIPS core control
//            path (scoreboard entry layout, forwarding select encoding).
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Architectural register address width (32 GPRs).
    localparam int REG_AW = 5;

    // Forwarding select value meaning "use the operand read from the
    // register file and carried in the ID/EX register".
    localparam int FWD_REGFILE = 0;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } sb_entry_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// ============================================================================
// Module   : hazard_match
// Summary  : Compares one operand source (in its EX and ID incarnations)
//            against a single scoreboard entry. Produces a forwarding hit for
//            the EX operand and a load-use hit for the ID operand, both
//            qualified by the entry's stage position relative to LOAD_RDY.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_match
    import cpu_pkg::*;
#(
    parameter int STAGE    = 0,
    parameter int LOAD_RDY = 2
) (
    input  logic [REG_AW-1:0] i_ex_addr,
    input  logic              i_ex_use,
    input  logic [REG_AW-1:0] i_id_addr,
    input  logic              i_id_use,
    input  sb_entry_t         i_entry,
    output logic              o_fwd_hit,
    output logic              o_load_hit
);

    // Stage 0 holds the EX instruction itself, so it can never feed EX.
    localparam bit c_can_fwd    = (STAGE != 0);
    // Load data exists from LOAD_RDY onwards.
    localparam bit c_load_fwd   = (STAGE >= LOAD_RDY);
    // A load here would still be too young once the ID instruction enters EX.
    localparam bit c_load_early = ((STAGE + 1) < LOAD_RDY);

    logic w_live;
    logic w_ex_eq;
    logic w_id_eq;

    // Only a valid register-writing entry with a non-zero destination can
    // produce a value anybody depends on ($0 is hardwired).
    assign w_live  = i_entry.valid & i_entry.regwrite & (i_entry.rd != '0);
    assign w_ex_eq = i_ex_use & (i_entry.rd == i_ex_addr);
    assign w_id_eq = i_id_use & (i_entry.rd == i_id_addr);

    assign o_fwd_hit  = c_can_fwd & w_live & w_ex_eq
                      & (~i_entry.memread | c_load_fwd);
    assign o_load_hit = c_load_early & w_live & w_id_eq & i_entry.memread;

endmodule : hazard_match
`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_ctrl
// Summary  : Parametrised hazard / forwarding controller. Tracks the
//            destination of every instruction in the NSTAGE stages after ID
//            (stage 0 = EX ... NSTAGE-1 = WB), selects forwarding sources for
//            the EX operands and generates load-use stall, bubble and flush
//            controls for PC, IF/ID and ID/EX.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_ctrl #(
    // Must equal cpu_pkg::REG_AW: scoreboard entries use the package struct.
    parameter int REG_AW   = cpu_pkg::REG_AW,
    parameter int NSTAGE   = 3,
    parameter int LOAD_RDY = 2,
    parameter int CNT_W    = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      id_valid_i,
    input  logic [REG_AW-1:0]         id_rs_i,
    input  logic [REG_AW-1:0]         id_rt_i,
    input  logic                      id_use_rs_i,
    input  logic                      id_use_rt_i,
    input  logic [REG_AW-1:0]         id_rd_i,
    input  logic                      id_regwrite_i,
    input  logic                      id_memread_i,
    input  logic                      flush_i,
    input  logic                      ex_stall_i,
    output logic                      pcwrite_o,
    output logic                      ifid_write_o,
    output logic                      ifid_flush_o,
    output logic                      idex_bubble_o,
    output logic [$clog2(NSTAGE)-1:0] fwd_rs_o,
    output logic [$clog2(NSTAGE)-1:0] fwd_rt_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);
    import cpu_pkg::*;

    localparam int c_fwd_w = $clog2(NSTAGE);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    sb_entry_t         r_sb [NSTAGE];
    logic [REG_AW-1:0] r_ex_rs;
    logic [REG_AW-1:0] r_ex_rt;
    logic              r_ex_use_rs;
    logic              r_ex_use_rt;
    logic [CNT_W-1:0]  r_stall_cnt;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [NSTAGE-1:0]  w_fwd_hit_rs;
    logic [NSTAGE-1:0]  w_fwd_hit_rt;
    logic [NSTAGE-1:0]  w_load_hit_rs;
    logic [NSTAGE-1:0]  w_load_hit_rt;
    logic               w_load_use;
    logic               w_advance;
    logic               w_do_flush;
    logic               w_do_stall;
    sb_entry_t          w_issue;
    logic               w_issue_use_rs;
    logic               w_issue_use_rt;
    logic [c_fwd_w-1:0] w_fwd_rs;
    logic [c_fwd_w-1:0] w_fwd_rt;

    // One comparator pair per stage: RS and RT each checked against the
    // entry for both forwarding (EX operand) and load-use (ID operand).
    generate
        for (genvar k = 0; k < NSTAGE; k++) begin : g_match
            hazard_match #(
                .STAGE    (k),
                .LOAD_RDY (LOAD_RDY)
            ) u_rs (
                .i_ex_addr  (r_ex_rs),
                .i_ex_use   (r_ex_use_rs),
                .i_id_addr  (id_rs_i),
                .i_id_use   (id_use_rs_i),
                .i_entry    (r_sb[k]),
                .o_fwd_hit  (w_fwd_hit_rs[k]),
                .o_load_hit (w_load_hit_rs[k])
            );

            hazard_match #(
                .STAGE    (k),
                .LOAD_RDY (LOAD_RDY)
            ) u_rt (
                .i_ex_addr  (r_ex_rt),
                .i_ex_use   (r_ex_use_rt),
                .i_id_addr  (id_rt_i),
                .i_id_use   (id_use_rt_i),
                .i_entry    (r_sb[k]),
                .o_fwd_hit  (w_fwd_hit_rt[k]),
                .o_load_hit (w_load_hit_rt[k])
            );
        end
    endgenerate

    // Pipeline control: back-pressure beats flush, flush beats load-use.
    always_comb begin
        w_load_use    = id_valid_i & ((|w_load_hit_rs) | (|w_load_hit_rt));
        w_advance     = ~ex_stall_i;
        w_do_flush    = w_advance & flush_i;
        w_do_stall    = w_advance & ~flush_i & w_load_use;

        pcwrite_o     = w_advance & ~w_do_stall;
        ifid_write_o  = w_advance & ~w_do_stall;
        ifid_flush_o  = w_do_flush;
        idex_bubble_o = w_do_stall;
    end

    // Entry entering EX: a bubble on flush or load-use, else the ID fields.
    always_comb begin
        w_issue          = '0;
        w_issue_use_rs   = 1'b0;
        w_issue_use_rt   = 1'b0;
        if (!(w_do_flush || w_do_stall)) begin
            w_issue.valid    = id_valid_i;
            w_issue.rd       = id_rd_i;
            w_issue.regwrite = id_regwrite_i;
            w_issue.memread  = id_memread_i;
            w_issue_use_rs   = id_valid_i & id_use_rs_i;
            w_issue_use_rt   = id_valid_i & id_use_rt_i;
        end
    end

    // Scoreboard shift, EX source capture and stall counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NSTAGE; k++) begin
                r_sb[k] <= '0;
            end
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_use_rs <= 1'b0;
            r_ex_use_rt <= 1'b0;
            r_stall_cnt <= '0;
        end else if (w_advance) begin
            r_sb[0] <= w_issue;
            for (int k = 1; k < NSTAGE; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
            r_ex_rs     <= id_rs_i;
            r_ex_rt     <= id_rt_i;
            r_ex_use_rs <= w_issue_use_rs;
            r_ex_use_rt <= w_issue_use_rt;
            if (w_do_stall) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // Youngest producer wins: scan oldest to youngest so the last hit sticks.
    always_comb begin
        w_fwd_rs = c_fwd_w'(FWD_REGFILE);
        w_fwd_rt = c_fwd_w'(FWD_REGFILE);
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (w_fwd_hit_rs[k]) begin
                w_fwd_rs = c_fwd_w'(k);
            end
            if (w_fwd_hit_rt[k]) begin
                w_fwd_rt = c_fwd_w'(k);
            end
        end
    end

    assign fwd_rs_o    = w_fwd_rs;
    assign fwd_rt_o    = w_fwd_rt;
    assign stall_cnt_o = r_stall_cnt;

endmodule : hazard_fwd_ctrl
`default_nettype wire
